// File: rtl/neuron_detect_stream_pkg.sv
// Shared types and constants for the seizure detection stream.
// Holds the frame/debounce state encodings, default widths and saturation bounds.
package neurondetect_pkg;

    typedef enum logic {
        ST_ACCUM,
        ST_EVAL
    } frame_state_t;

    typedef enum logic {
        ST_CLEAR,
        ST_ACTIVE
    } deb_state_t;

    localparam int DEF_SUM_W  = 12;
    localparam int DEF_ACC_W  = 16;
    localparam int DEF_THRESH = 422;

    // Most positive / most negative value of a signed acc_w-bit accumulator.
    function automatic longint sat_max(input int acc_w);
        return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int acc_w);
        return -(64'sd1 <<< (acc_w - 1));
    endfunction

endpackage

// File: rtl/neuron_detect_stream_sat_accum.sv
// Signed accumulator: sign-extends each input and adds with saturation.
// 'sum' is the saturated next value, usable before it is registered.
module sat_accum
    import neurondetect_pkg::*;
#(
    parameter int IN_W  = DEF_SUM_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [IN_W-1:0]  din,
    output logic [ACC_W-1:0] acc,
    output logic [ACC_W-1:0] sum
);

    localparam logic [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W));

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W:0]   wide;

    // One guard bit: overflow shows as the top two bits disagreeing.
    assign wide = {acc_reg[ACC_W-1], acc_reg} + {{(ACC_W + 1 - IN_W){din[IN_W-1]}}, din};

    always_comb begin
        sum = wide[ACC_W-1:0];
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            sum = wide[ACC_W] ? MIN_V : MAX_V;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= sum;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/neuron_detect_stream.sv
// Frame accumulator, threshold compare and onset/offset debounce for the
// serialised per-channel weighted sums.
module neuron_detect_stream
    import neurondetect_pkg::*;
#(
    parameter int NUM_CH     = 16,
    parameter int SUM_W      = DEF_SUM_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int ONSET_CNT  = 3,
    parameter int OFFSET_CNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ws_valid,
    output logic             ws_ready,
    input  logic [SUM_W-1:0] ws_data,
    input  logic             ws_last,
    input  logic [ACC_W-1:0] thresh,
    output logic [ACC_W-1:0] score,
    output logic             score_valid,
    output logic             seizure,
    output logic             onset,
    output logic             offset,
    output logic             frame_err
);

    localparam int CH_W    = $clog2(NUM_CH);
    localparam int CNT_MAX = (ONSET_CNT > OFFSET_CNT) ? ONSET_CNT : OFFSET_CNT;
    localparam int DCNT_W  = $clog2(CNT_MAX + 1);

    frame_state_t      state_reg, state_next;
    deb_state_t        dstate_reg, dstate_next;
    logic [CH_W-1:0]   ch_cnt_reg, ch_cnt_next;
    logic [DCNT_W-1:0] dcnt_reg, dcnt_next;
    logic              ws_ready_reg, ws_ready_next;
    logic [ACC_W-1:0]  score_reg, score_next;
    logic              score_valid_reg, score_valid_next;
    logic              seizure_reg, seizure_next;
    logic              onset_reg, onset_next;
    logic              offset_reg, offset_next;
    logic              frame_err_reg, frame_err_next;

    logic              acc_clr, acc_en, hit;
    logic              beat, at_end;
    logic [ACC_W-1:0]  acc_val, acc_sum;

    sat_accum #(
        .IN_W (SUM_W),
        .ACC_W(ACC_W)
    ) u_acc (
        .clk(clk),
        .rst(rst),
        .clr(acc_clr),
        .en (acc_en),
        .din(ws_data),
        .acc(acc_val),
        .sum(acc_sum)
    );

    assign beat   = ws_valid & ws_ready_reg;
    assign at_end = (ch_cnt_reg == CH_W'(NUM_CH - 1));

    always_comb begin
        state_next       = state_reg;
        dstate_next      = dstate_reg;
        ch_cnt_next      = ch_cnt_reg;
        dcnt_next        = dcnt_reg;
        ws_ready_next    = !en;
        score_next       = score_reg;
        score_valid_next = 1'b0;
        onset_next       = 1'b0;
        offset_next      = 1'b0;
        frame_err_next   = 1'b0;
        acc_clr          = 1'b0;
        acc_en           = 1'b0;
        hit              = 1'b0;

        case (state_reg)
            ST_ACCUM: begin
                if (beat) begin
                    if (ws_last && at_end) begin
                        // Score is registered from the saturated sum so it is
                        // visible during the EVAL cycle itself.
                        acc_en           = 1'b1;
                        ch_cnt_next      = '0;
                        score_next       = acc_sum;
                        score_valid_next = 1'b1;
                        ws_ready_next    = 1'b0;
                        state_next       = ST_EVAL;
                    end else if (ws_last || at_end) begin
                        acc_clr        = 1'b1;
                        ch_cnt_next    = '0;
                        frame_err_next = 1'b1;
                    end else begin
                        acc_en      = 1'b1;
                        ch_cnt_next = ch_cnt_reg + CH_W'(1);
                    end
                end
            end
            ST_EVAL: begin
                acc_clr    = 1'b1;
                state_next = ST_ACCUM;
                hit        = ($signed(acc_val) >= $signed(thresh));
                case (dstate_reg)
                    ST_CLEAR: begin
                        if (!hit) begin
                            dcnt_next = '0;
                        end else if (int'(dcnt_reg) + 1 == ONSET_CNT) begin
                            dcnt_next   = '0;
                            dstate_next = ST_ACTIVE;
                            onset_next  = 1'b1;
                        end else begin
                            dcnt_next = dcnt_reg + DCNT_W'(1);
                        end
                    end
                    ST_ACTIVE: begin
                        if (hit) begin
                            dcnt_next = '0;
                        end else if (int'(dcnt_reg) + 1 == OFFSET_CNT) begin
                            dcnt_next   = '0;
                            dstate_next = ST_CLEAR;
                            offset_next = 1'b1;
                        end else begin
                            dcnt_next = dcnt_reg + DCNT_W'(1);
                        end
                    end
                    default: dstate_next = ST_CLEAR;
                endcase
            end
            default: state_next = ST_ACCUM;
        endcase

        seizure_next = (dstate_next == ST_ACTIVE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_ACCUM;
            dstate_reg      <= ST_CLEAR;
            ch_cnt_reg      <= '0;
            dcnt_reg        <= '0;
            ws_ready_reg    <= 1'b0;
            score_reg       <= '0;
            score_valid_reg <= 1'b0;
            seizure_reg     <= 1'b0;
            onset_reg       <= 1'b0;
            offset_reg      <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            dstate_reg      <= dstate_next;
            ch_cnt_reg      <= ch_cnt_next;
            dcnt_reg        <= dcnt_next;
            ws_ready_reg    <= ws_ready_next;
            score_reg       <= score_next;
            score_valid_reg <= score_valid_next;
            seizure_reg     <= seizure_next;
            onset_reg       <= onset_next;
            offset_reg      <= offset_next;
            frame_err_reg   <= frame_err_next;
        end
    end

    assign ws_ready    = ws_ready_reg;
    assign score       = score_reg;
    assign score_valid = score_valid_reg;
    assign seizure     = seizure_reg;
    assign onset       = onset_reg;
    assign offset      = offset_reg;
    assign frame_err   = frame_err_reg;

endmodule

// File: tb/tb_neuron_detect_stream.sv
// Directed and randomized frames checked against a frame-level model of
// saturating accumulation, threshold compare and persistence debounce.
module tb_neuron_detect_stream;

    localparam int NUM_CH = 16;
    localparam int SUM_W  = 12;
    localparam int ACC_W  = 14;
    localparam int ONSET  = 3;
    localparam int OFFSET = 3;
    localparam int SMAX   = (1 << (ACC_W - 1)) - 1;
    localparam int SMIN   = -(1 << (ACC_W - 1));

    logic             clk;
    logic             rst;
    logic             en;
    logic             ws_valid;
    logic             ws_ready;
    logic [SUM_W-1:0] ws_data;
    logic             ws_last;
    logic [ACC_W-1:0] thresh;
    logic [ACC_W-1:0] score;
    logic             score_valid;
    logic             seizure;
    logic             onset;
    logic             offset;
    logic             frame_err;

    neuron_detect_stream #(
        .NUM_CH    (NUM_CH),
        .SUM_W     (SUM_W),
        .ACC_W     (ACC_W),
        .ONSET_CNT (ONSET),
        .OFFSET_CNT(OFFSET)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ws_valid   (ws_valid),
        .ws_ready   (ws_ready),
        .ws_data    (ws_data),
        .ws_last    (ws_last),
        .thresh     (thresh),
        .score      (score),
        .score_valid(score_valid),
        .seizure    (seizure),
        .onset      (onset),
        .offset     (offset),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int fq[$];
    int thresh_i;
    int m_level = 0;
    int m_streak = 0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, want);
        end
    endtask

    task automatic set_thresh(input int t);
        thresh_i = t;
        thresh   = ACC_W'(t);
    endtask

    task automatic fill(input int n, input int v);
        for (int i = 0; i < n; i++) fq.push_back(v);
    endtask

    // Frame score: running sum clamped to the accumulator range after every beat.
    function automatic int model_score();
        int acc = 0;
        foreach (fq[i]) begin
            acc = acc + fq[i];
            if (acc > SMAX) acc = SMAX;
            if (acc < SMIN) acc = SMIN;
        end
        return acc;
    endfunction

    task automatic put_beat(input int d, input logic last);
        int guard = 0;
        ws_data  = SUM_W'(d);
        ws_last  = last;
        ws_valid = 1'b1;
        @(negedge clk);
        while (ws_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("beat_ready_timeout", ws_ready, 1);
        @(posedge clk);
        #1;
        ws_valid = 1'b0;
        ws_last  = 1'b0;
    endtask

    task automatic drive(input int lo, input int hi, input int last_at,
                         input int gap_max, input bit jitter);
        @(posedge clk);
        #1;
        for (int i = lo; i < hi; i++) begin
            int g;
            g = $urandom_range(0, gap_max);
            for (int k = 0; k < g; k++) begin
                @(posedge clk);
                #1;
            end
            if (jitter && $urandom_range(0, 3) == 0)
                set_thresh(int'($urandom_range(0, 1200)) - 200);
            put_beat(fq[i], i == last_at);
        end
    endtask

    task automatic eval_check();
        int want;
        bit hit;
        bit progress;
        int on;
        int off;
        want = model_score();
        on = 0;
        off = 0;
        @(negedge clk);
        check("score_valid", score_valid, 1);
        check("score", $signed(score), want);
        check("frame_err_quiet", frame_err, 0);
        hit = (want >= thresh_i);
        progress = (m_level == 0) ? hit : !hit;
        if (progress) begin
            m_streak++;
            if (m_streak == ((m_level == 1) ? OFFSET : ONSET)) begin
                m_level  = 1 - m_level;
                m_streak = 0;
                if (m_level == 1) on = 1; else off = 1;
            end
        end else begin
            m_streak = 0;
        end
        @(negedge clk);
        check("seizure", seizure, m_level);
        check("onset", onset, on);
        check("offset", offset, off);
        check("ready_after_eval", ws_ready, 1);
        check("score_valid_pulse", score_valid, 0);
        $display("[TB] frame score=%0d thresh=%0d hit=%0d seizure=%0d onset=%0d offset=%0d",
                 $signed(score), thresh_i, hit, seizure, onset, offset);
    endtask

    task automatic good_frame(input int gap_max, input bit jitter);
        drive(0, fq.size(), fq.size() - 1, gap_max, jitter);
        eval_check();
        fq.delete();
    endtask

    task automatic bad_frame(input int n, input int last_at);
        drive(0, n, last_at, 0, 1'b0);
        @(negedge clk);
        check("frame_err", frame_err, 1);
        check("misframe_no_score", score_valid, 0);
        check("misframe_ready", ws_ready, 1);
        @(negedge clk);
        check("frame_err_pulse", frame_err, 0);
        check("misframe_seizure", seizure, m_level);
        $display("[TB] misframe beats=%0d last_at=%0d frame_err_seen", n, last_at);
        fq.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, ws_ready, 0);
        check({tag, "_score"}, $signed(score), 0);
        check({tag, "_score_valid"}, score_valid, 0);
        check({tag, "_seizure"}, seizure, 0);
        check({tag, "_onset"}, onset, 0);
        check({tag, "_offset"}, offset, 0);
        check({tag, "_frame_err"}, frame_err, 0);
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        ws_valid = 1'b0;
        ws_data = '0;
        ws_last = 1'b0;
        set_thresh(422);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", ws_ready, 1);

        // Threshold boundary: 422 hits, 416 misses and clears the streak.
        fill(15, 26); fill(1, 32); good_frame(0, 1'b0);
        fill(16, 26); good_frame(0, 1'b0);

        // Three hit frames raise seizure on the third.
        for (int f = 0; f < 3; f++) begin
            fill(16, 27);
            good_frame(1, 1'b0);
        end
        check("onset_reached", seizure, 1);

        // Misframes: early ws_last, then missing ws_last.
        fill(10, 27); bad_frame(10, 9);
        fill(16, 27); good_frame(0, 1'b0);
        fill(16, 27); bad_frame(16, -1);
        fill(16, 27); good_frame(0, 1'b0);

        // Hysteresis then offset.
        for (int f = 0; f < 4; f++) begin
            fill(16, 0); good_frame(0, 1'b0);
            fill(16, 27); good_frame(0, 1'b0);
        end
        check("hysteresis_hold", seizure, 1);
        for (int f = 0; f < 3; f++) begin
            fill(16, 0); good_frame(0, 1'b0);
        end
        check("offset_reached", seizure, 0);

        // Saturation at both rails, and continued adding from the clamp.
        fill(16, 2047); good_frame(0, 1'b0);
        fill(16, -2048); good_frame(0, 1'b0);
        fill(8, 2047); fill(8, -2048); good_frame(0, 1'b0);

        // Reset mid-frame while seizure is asserted.
        for (int f = 0; f < 3; f++) begin
            fill(16, 27); good_frame(0, 1'b0);
        end
        fill(8, 27);
        drive(0, 8, -1, 0, 1'b0);
        fq.delete();
        #2 rst = 1'b0;
        #1;
        check_all_zero("midreset");
        m_level = 0;
        m_streak = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        fill(16, 27); good_frame(0, 1'b0);

        // Enable high blocks acceptance even with valid asserted.
        @(posedge clk);
        #1 en = 1'b1;
        @(posedge clk);
        #1;
        ws_valid = 1'b1;
        ws_data = SUM_W'(500);
        ws_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("en_blocks_ready", ws_ready, 0);
            check("en_no_frame_err", frame_err, 0);
            @(posedge clk);
            #1;
        end
        ws_valid = 1'b0;
        en = 1'b0;
        fill(16, 27); good_frame(0, 1'b0);

        // Mid-frame pause: acc and channel count hold across the enable gap.
        fill(8, 27); fill(8, 13);
        drive(0, 8, -1, 0, 1'b0);
        en = 1'b1;
        @(posedge clk);
        #1;
        ws_valid = 1'b1;
        ws_data = SUM_W'(300);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("pause_ready", ws_ready, 0);
            @(posedge clk);
            #1;
        end
        ws_valid = 1'b0;
        en = 1'b0;
        drive(8, 16, 15, 0, 1'b0);
        eval_check();
        fq.delete();

        // Randomized frames with gaps, threshold churn and occasional misframes.
        for (int r = 0; r < 24; r++) begin
            int mode;
            mode = $urandom_range(0, 2);
            set_thresh(int'($urandom_range(0, 1200)) - 200);
            for (int i = 0; i < NUM_CH; i++) begin
                if (mode == 0) fq.push_back(int'($urandom_range(0, 60)));
                else if (mode == 1) fq.push_back(int'($urandom_range(0, 4095)) - 2048);
                else fq.push_back(int'($urandom_range(1500, 2047)));
            end
            if ($urandom_range(0, 5) == 0) begin
                int la;
                la = $urandom_range(0, NUM_CH - 2);
                bad_frame(la + 1, la);
            end else begin
                good_frame(2, 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
